// File: rtl/lif_sched_pkg.sv
// Shared types and helpers for the time-multiplexed LIF scheduler.
package lif_sched_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } sched_state_t;

   // Index width that stays at least one bit for degenerate sizes.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int sat_max(input int w);
      return (w >= 31) ? 32'h7fff_ffff : ((1 << w) - 1);
   endfunction

   localparam int SAT_MAX_W8 = sat_max(8);

endpackage

// File: rtl/lif_tdm_scheduler_lif_update.sv
// Combinational single-neuron leaky-integrate-and-fire step with saturating sum.
module lif_update
   import lif_sched_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int THRESHOLD  = 128,
   parameter int LEAK_SHIFT = 1
) (
   input  logic [WIDTH-1:0] state,
   input  logic [WIDTH-1:0] stim,
   output logic [WIDTH-1:0] next_state,
   output logic             spike
);

   localparam int              SAT_INT = sat_max(WIDTH);
   localparam logic [WIDTH-1:0] SAT_MAX = SAT_INT[WIDTH-1:0];
   localparam logic [WIDTH-1:0] THRESH  = WIDTH'(THRESHOLD);

   function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH:0] v);
      return v[WIDTH] ? SAT_MAX : v[WIDTH-1:0];
   endfunction

   logic [WIDTH:0]   sum_raw;
   logic [WIDTH-1:0] sum_sat;

   always_comb begin
      sum_raw    = {1'b0, (state >> LEAK_SHIFT)} + {1'b0, stim};
      sum_sat    = saturate(sum_raw);
      spike      = (sum_sat >= THRESH);
      next_state = spike ? '0 : sum_sat;
   end

endmodule

// File: rtl/lif_tdm_scheduler.sv
// LIF engine sweeping N neuron states through one shared update datapath per tick.
// Optional refractory counters are built when LIF_SCHED_REFRACTORY_EN is defined.
module lif_tdm_scheduler
   import lif_sched_pkg::*;
#(
   parameter int N_NEURONS     = 4,
   parameter int WIDTH         = 8,
   parameter int THRESHOLD     = 128,
   parameter int LEAK_SHIFT    = 1,
   parameter int REFRACT_STEPS = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       tick,
   input  logic [N_NEURONS*WIDTH-1:0] cur_in,
   input  logic [N_NEURONS-1:0]       chain_mask,
   input  logic [idx_width(N_NEURONS)-1:0] state_sel,
   output logic [WIDTH-1:0]           state_out,
   output logic [N_NEURONS-1:0]       spikes,
   output logic                       busy,
   output logic                       done,
   output logic                       overrun
);

   localparam int IDX_W = idx_width(N_NEURONS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

   sched_state_t     st, st_next;
   logic [IDX_W-1:0] idx, idx_next;
   logic             upd_en, last;

   logic [WIDTH-1:0]     states [N_NEURONS];
   logic [N_NEURONS-1:0] shadow, shadow_new;
   logic [N_NEURONS-1:0] spikes_q;
   logic                 overrun_q;

   logic [WIDTH-1:0] cur_state, chain_src, ext_src, sel_src, stim;
   logic [WIDTH-1:0] upd_state;
   logic             upd_spike, chain_sel, stim_block;

   always_comb begin
      st_next  = st;
      idx_next = idx;
      upd_en   = 1'b0;
      last     = 1'b0;
      case (st)
         IDLE: begin
            if (tick) begin
               st_next  = RUN;
               idx_next = '0;
            end
         end
         RUN: begin
            upd_en = 1'b1;
            if (idx == LAST_IDX) begin
               st_next = DONE;
               last    = 1'b1;
            end else begin
               idx_next = idx + 1'b1;
            end
         end
         DONE:    st_next = IDLE;
         default: st_next = IDLE;
      endcase
   end

   // Neuron idx-1 was written on an earlier cycle, so chaining sees this sweep's value.
   always_comb begin
      cur_state = states[idx];
      chain_src = states[idx - 1'b1];
      ext_src   = cur_in[idx*WIDTH +: WIDTH];
      chain_sel = chain_mask[idx] && (idx != '0);
      sel_src   = chain_sel ? chain_src : ext_src;
      stim      = stim_block ? '0 : sel_src;
   end

   lif_update #(
      .WIDTH      (WIDTH),
      .THRESHOLD  (THRESHOLD),
      .LEAK_SHIFT (LEAK_SHIFT)
   ) u_update (
      .state      (cur_state),
      .stim       (stim),
      .next_state (upd_state),
      .spike      (upd_spike)
   );

   always_comb begin
      shadow_new      = shadow;
      shadow_new[idx] = upd_spike;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st        <= IDLE;
         idx       <= '0;
         shadow    <= '0;
         spikes_q  <= '0;
         overrun_q <= 1'b0;
         for (int k = 0; k < N_NEURONS; k++) states[k] <= '0;
      end else begin
         st  <= st_next;
         idx <= idx_next;
         if (upd_en) begin
            states[idx] <= upd_state;
            shadow      <= shadow_new;
         end
         if (last) spikes_q <= shadow_new;
         if (tick && (st != IDLE)) overrun_q <= 1'b1;
      end
   end

`ifdef LIF_SCHED_REFRACTORY_EN
   localparam int CNT_W = idx_width(REFRACT_STEPS + 1);
   localparam logic [CNT_W-1:0] REFRACT_LOAD = CNT_W'(REFRACT_STEPS);

   logic [CNT_W-1:0] refr_cnt [N_NEURONS];

   assign stim_block = (refr_cnt[idx] != '0);

   // A refractory neuron still leaks; its counter ticks down once per visit.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < N_NEURONS; k++) refr_cnt[k] <= '0;
      end else if (upd_en) begin
         if (upd_spike)       refr_cnt[idx] <= REFRACT_LOAD;
         else if (stim_block) refr_cnt[idx] <= refr_cnt[idx] - 1'b1;
      end
   end
`else
   assign stim_block = 1'b0;
`endif

   always_comb begin
      state_out = '0;
      if (int'(state_sel) < N_NEURONS) state_out = states[state_sel];
   end

   assign spikes  = spikes_q;
   assign busy    = (st != IDLE);
   assign done    = (st == DONE);
   assign overrun = overrun_q;

endmodule

// File: tb/tb_lif_tdm_scheduler.sv
// Directed bench for lif_tdm_scheduler; a second instance runs with THRESHOLD=255.
module tb_lif_tdm_scheduler;

   localparam int N = 4;
   localparam int W = 8;

   logic           clk = 1'b0;
   logic           rst, tick;
   logic [N*W-1:0] cur_in;
   logic [N-1:0]   chain_mask;
   logic [1:0]     state_sel;

   logic [W-1:0] state_out, s_state_out;
   logic [N-1:0] spikes, s_spikes;
   logic         busy, done, overrun, s_busy, s_done, s_overrun;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   lif_tdm_scheduler #(.N_NEURONS(N), .WIDTH(W), .THRESHOLD(128), .LEAK_SHIFT(1), .REFRACT_STEPS(2)) dut (
      .clk(clk), .rst(rst), .tick(tick), .cur_in(cur_in), .chain_mask(chain_mask),
      .state_sel(state_sel), .state_out(state_out), .spikes(spikes), .busy(busy),
      .done(done), .overrun(overrun));

   lif_tdm_scheduler #(.N_NEURONS(N), .WIDTH(W), .THRESHOLD(255), .LEAK_SHIFT(1), .REFRACT_STEPS(2)) dut_sat (
      .clk(clk), .rst(rst), .tick(tick), .cur_in(cur_in), .chain_mask(chain_mask),
      .state_sel(state_sel), .state_out(s_state_out), .spikes(s_spikes), .busy(s_busy),
      .done(s_done), .overrun(s_overrun));

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cur(input int k, input logic [W-1:0] v);
      cur_in[k*W +: W] = v;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick = 1'b0;
      cyc();
      cyc();
      rst = 1'b0;
   endtask

   // Tick once, wait for done (bounded), then step back into IDLE.
   task automatic sweep();
      bit seen;
      seen = 1'b0;
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         if (done) seen = 1'b1;
         else cyc();
      end
      checks++;
      if (seen !== 1'b1) begin
         errors++;
         $display("FAIL sweep_done: done seen=%0d, required 1", seen);
      end
      cyc();
   endtask

   task automatic test_reset();
      cur_in = '1;
      chain_mask = '1;
      state_sel = '0;
      do_reset();
      checks++; if (spikes !== 4'b0000) begin errors++; $display("FAIL rst_spikes: got %b want 0000", spikes); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b want 0", overrun); end
      for (int k = 0; k < N; k++) begin
         state_sel = 2'(k);
         #1;
         checks++;
         if (state_out !== 8'd0) begin errors++; $display("FAIL rst_state%0d: got %0d want 0", k, state_out); end
      end
   endtask

   task automatic test_basic_sweep();
      cur_in = '0;
      chain_mask = '0;
      do_reset();
      set_cur(0, 8'd100);
      tick = 1'b1;
      for (int c = 1; c <= 6; c++) begin
         cyc();
         tick = 1'b0;
         checks++;
         if (busy !== (c <= 5)) begin errors++; $display("FAIL basic_busy_c%0d: got %b want %b", c, busy, (c <= 5)); end
         checks++;
         if (done !== (c == 5)) begin errors++; $display("FAIL basic_done_c%0d: got %b want %b", c, done, (c == 5)); end
         if (c == 5) begin
            checks++;
            if (spikes !== 4'b0000) begin errors++; $display("FAIL basic_spikes1: got %b want 0000", spikes); end
         end
      end
      state_sel = 2'd0; #1;
      checks++; if (state_out !== 8'd100) begin errors++; $display("FAIL basic_state0: got %0d want 100", state_out); end
      state_sel = 2'd3; #1;
      checks++; if (state_out !== 8'd0) begin errors++; $display("FAIL basic_state3: got %0d want 0", state_out); end
      sweep();
      checks++; if (spikes !== 4'b0001) begin errors++; $display("FAIL basic_spikes2: got %b want 0001", spikes); end
      state_sel = 2'd0; #1;
      checks++; if (state_out !== 8'd0) begin errors++; $display("FAIL basic_state0_after_spike: got %0d want 0", state_out); end
   endtask

   task automatic test_saturation();
      cur_in = '0;
      chain_mask = '0;
      do_reset();
      set_cur(1, 8'd200);
      sweep();
      state_sel = 2'd1; #1;
      checks++; if (s_state_out !== 8'd200) begin errors++; $display("FAIL sat_state1_sweep1: got %0d want 200", s_state_out); end
      checks++; if (s_spikes !== 4'b0000) begin errors++; $display("FAIL sat_spikes_sweep1: got %b want 0000", s_spikes); end
      checks++; if (spikes !== 4'b0010) begin errors++; $display("FAIL thr128_spikes_sweep1: got %b want 0010", spikes); end
      sweep();
      state_sel = 2'd1; #1;
      checks++; if (s_spikes !== 4'b0010) begin errors++; $display("FAIL sat_spikes_sweep2: got %b want 0010", s_spikes); end
      checks++; if (s_state_out !== 8'd0) begin errors++; $display("FAIL sat_state1_sweep2: got %0d want 0", s_state_out); end
   endtask

   task automatic test_chain();
      cur_in = '0;
      do_reset();
      chain_mask = 4'b0010;
      set_cur(0, 8'd100);
      sweep();
      state_sel = 2'd0; #1;
      checks++; if (state_out !== 8'd100) begin errors++; $display("FAIL chain_state0: got %0d want 100", state_out); end
      state_sel = 2'd1; #1;
      checks++; if (state_out !== 8'd100) begin errors++; $display("FAIL chain_state1: got %0d want 100", state_out); end
      set_cur(0, 8'd200);
      sweep();
      checks++; if (spikes !== 4'b0001) begin errors++; $display("FAIL chain_spikes: got %b want 0001", spikes); end
      state_sel = 2'd0; #1;
      checks++; if (state_out !== 8'd0) begin errors++; $display("FAIL chain_state0_spk: got %0d want 0", state_out); end
      state_sel = 2'd1; #1;
      checks++; if (state_out !== 8'd50) begin errors++; $display("FAIL chain_state1_leak: got %0d want 50", state_out); end
      // Threshold 255: neuron0 holds 250, neuron1 sees 50+250 which saturates and fires.
      checks++; if (s_spikes !== 4'b0010) begin errors++; $display("FAIL chain_sat_spikes: got %b want 0010", s_spikes); end
      state_sel = 2'd0; #1;
      checks++; if (s_state_out !== 8'd250) begin errors++; $display("FAIL chain_sat_state0: got %0d want 250", s_state_out); end
      chain_mask = '0;
   endtask

   task automatic test_overrun_and_reset();
      int dcnt, dcyc;
      cur_in = {8'd50, 8'd50, 8'd50, 8'd150};
      chain_mask = '0;
      do_reset();
      dcnt = 0;
      dcyc = -1;
      tick = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         cyc();
         tick = (c == 2);
         if (done) begin dcnt++; dcyc = c; end
      end
      checks++; if (dcnt !== 1) begin errors++; $display("FAIL ovr_done_count: got %0d want 1", dcnt); end
      checks++; if (dcyc !== 5) begin errors++; $display("FAIL ovr_done_cycle: got %0d want 5", dcyc); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag: got %b want 1", overrun); end
      checks++; if (spikes !== 4'b0001) begin errors++; $display("FAIL ovr_spikes: got %b want 0001", spikes); end
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
      cyc();
      state_sel = 2'd1; #1;
      checks++; if (state_out !== 8'd75) begin errors++; $display("FAIL mid_state1: got %0d want 75", state_out); end
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
      dcnt = 0;
      for (int c = 0; c < 8; c++) begin
         if (done) dcnt++;
         cyc();
      end
      checks++; if (dcnt !== 0) begin errors++; $display("FAIL mid_rst_done: got %0d want 0", dcnt); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL mid_rst_overrun: got %b want 0", overrun); end
      checks++; if (spikes !== 4'b0000) begin errors++; $display("FAIL mid_rst_spikes: got %b want 0000", spikes); end
      for (int k = 0; k < N; k++) begin
         state_sel = 2'(k);
         #1;
         checks++;
         if (state_out !== 8'd0) begin errors++; $display("FAIL mid_rst_state%0d: got %0d want 0", k, state_out); end
      end
   endtask

   task automatic test_back_to_back();
      int dcnt;
      cur_in = '0;
      chain_mask = '0;
      do_reset();
      dcnt = 0;
      tick = 1'b1;
      for (int c = 1; c <= 14; c++) begin
         cyc();
         tick = (c == 6);
         if (done && (c == 5 || c == 11)) dcnt++;
      end
      checks++; if (dcnt !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d want 2", dcnt); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b want 0", overrun); end
      tick = 1'b1;
      for (int c = 1; c <= 8; c++) begin
         cyc();
         tick = (c == 5);
      end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL tick_in_done_overrun: got %b want 1", overrun); end
   endtask

   task automatic test_refractory();
`ifdef LIF_SCHED_REFRACTORY_EN
      logic [N-1:0] want_spk [4];
      want_spk[0] = 4'b0001;
      want_spk[1] = 4'b0000;
      want_spk[2] = 4'b0000;
      want_spk[3] = 4'b0001;
      cur_in = '0;
      chain_mask = '0;
      do_reset();
      set_cur(0, 8'd200);
      for (int s = 0; s < 4; s++) begin
         sweep();
         state_sel = 2'd0; #1;
         checks++;
         if (spikes !== want_spk[s]) begin errors++; $display("FAIL refr_spikes_s%0d: got %b want %b", s + 1, spikes, want_spk[s]); end
         checks++;
         if (state_out !== 8'd0) begin errors++; $display("FAIL refr_state0_s%0d: got %0d want 0", s + 1, state_out); end
      end
`endif
   endtask

   initial begin
      rst = 1'b0;
      tick = 1'b0;
      cur_in = '0;
      chain_mask = '0;
      state_sel = '0;
      test_reset();
      test_basic_sweep();
      test_saturation();
      test_chain();
      test_overrun_and_reset();
      test_back_to_back();
      test_refractory();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "timeout");
   end

endmodule
